// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: input exception codes,
// CP0 Cause.ExcCode values, sequencer state encoding and the decoder result.
package exc_pkg;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT0    = 32'h0000_0001;
    localparam logic [31:0] EXC_INT7    = 32'h0000_0008;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0009;
    localparam logic [31:0] EXC_BREAK   = 32'h0000_000a;
    localparam logic [31:0] EXC_RI      = 32'h0000_000b;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000d;

    localparam logic [4:0] EXCCODE_INT = 5'd0;
    localparam logic [4:0] EXCCODE_SYS = 5'd8;
    localparam logic [4:0] EXCCODE_BP  = 5'd9;
    localparam logic [4:0] EXCCODE_RI  = 5'd10;
    localparam logic [4:0] EXCCODE_OV  = 5'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_FLUSH,
        ST_REDIRECT
    } exc_state_t;

endpackage

// File: rtl/exc_code_map.sv
// Combinational decoder: pipeline exception code -> {valid, is_eret, exccode}.
// Codes outside 1..0xd decode as "no exception".
module exc_code_map
    import exc_pkg::*;
(
    input  logic [31:0] excepttype_i,
    output logic        valid_o,
    output logic        is_eret_o,
    output logic [4:0]  exccode_o
);

    always_comb begin
        valid_o   = 1'b0;
        is_eret_o = 1'b0;
        exccode_o = EXCCODE_INT;
        if (excepttype_i >= EXC_INT0 && excepttype_i <= EXC_INT7) begin
            valid_o = 1'b1;
        end else begin
            case (excepttype_i)
                EXC_SYSCALL: begin valid_o = 1'b1; exccode_o = EXCCODE_SYS; end
                EXC_BREAK:   begin valid_o = 1'b1; exccode_o = EXCCODE_BP;  end
                EXC_RI:      begin valid_o = 1'b1; exccode_o = EXCCODE_RI;  end
                EXC_OV:      begin valid_o = 1'b1; exccode_o = EXCCODE_OV;  end
                EXC_ERET:    begin valid_o = 1'b1; is_eret_o = 1'b1;        end
                default:     ;
            endcase
        end
    end

endmodule

// File: rtl/exception_sequencer.sv
// Sequences exception entry / eret return: CP0 update, pipeline flush and
// PC redirect with acknowledge. Outputs depend only on state and registers.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ST_IDLE     | waiting for a committing instruction with a valid code
//   ST_SAVE     | one-cycle CP0 write strobe (EPC/Cause/Status)
//   ST_FLUSH    | flush_o held for FLUSH_CYCLES cycles
//   ST_REDIRECT | redirect request held until redirect_ack_i
module exception_sequencer
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC   = 32'hBFC0_0380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] excepttype_i,
    input  logic        commit_valid_i,
    input  logic [31:0] pc_i,
    input  logic        in_delay_slot_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        redirect_ack_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic        cp0_we_o,
    output logic [31:0] epc_o,
    output logic [4:0]  exccode_o,
    output logic        bd_o,
    output logic        exl_set_o,
    output logic        exl_clr_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    exc_state_t  state, state_nxt;
    logic [3:0]  flush_cnt;
    logic        dec_valid, dec_eret;
    logic [4:0]  dec_exccode;
    logic        accept;

    logic        eret_q;
    logic        bd_q;
    logic [4:0]  exccode_q;
    logic [31:0] epc_q;
    logic [31:0] eret_tgt_q;

    exc_code_map u_code_map (
        .excepttype_i (excepttype_i),
        .valid_o      (dec_valid),
        .is_eret_o    (dec_eret),
        .exccode_o    (dec_exccode)
    );

    assign accept = (state == ST_IDLE) && commit_valid_i && dec_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            flush_cnt  <= '0;
            eret_q     <= 1'b0;
            bd_q       <= 1'b0;
            exccode_q  <= '0;
            epc_q      <= '0;
            eret_tgt_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                eret_q     <= dec_eret;
                bd_q       <= in_delay_slot_i;
                exccode_q  <= dec_exccode;
                // EPC points at the branch when the faulting instruction is in its delay slot
                epc_q      <= in_delay_slot_i ? (pc_i - 32'd4) : pc_i;
                eret_tgt_q <= cp0_epc_i;
            end
            if (state == ST_SAVE) begin
                flush_cnt <= FLUSH_LOAD;
            end else if (state == ST_FLUSH && flush_cnt != 4'd0) begin
                flush_cnt <= flush_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (accept) state_nxt = ST_SAVE;
            ST_SAVE:     state_nxt = ST_FLUSH;
            ST_FLUSH:    if (flush_cnt == 4'd0) state_nxt = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ack_i) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_o          = (state != ST_IDLE);
        flush_o          = (state == ST_FLUSH);
        cp0_we_o         = 1'b0;
        epc_o            = '0;
        exccode_o        = '0;
        bd_o             = 1'b0;
        exl_set_o        = 1'b0;
        exl_clr_o        = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        if (state == ST_SAVE) begin
            cp0_we_o = 1'b1;
            if (eret_q) begin
                exl_clr_o = 1'b1;
            end else begin
                exl_set_o = 1'b1;
                epc_o     = epc_q;
                exccode_o = exccode_q;
                bd_o      = bd_q;
            end
        end
        if (state == ST_REDIRECT) begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = eret_q ? eret_tgt_q : HANDLER_PC;
        end
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed self-checking bench for exception_sequencer (FLUSH_CYCLES = 2).
module tb_exception_sequencer;

    localparam logic [31:0] HPC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] excepttype_i;
    logic        commit_valid_i;
    logic [31:0] pc_i;
    logic        in_delay_slot_i;
    logic [31:0] cp0_epc_i;
    logic        redirect_ack_i;
    logic        stall_o, flush_o, cp0_we_o, bd_o, exl_set_o, exl_clr_o;
    logic        redirect_valid_o;
    logic [31:0] epc_o, redirect_pc_o;
    logic [4:0]  exccode_o;

    int n_tests = 0;
    int n_fail  = 0;

    exception_sequencer #(.HANDLER_PC(HPC), .FLUSH_CYCLES(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .excepttype_i     (excepttype_i),
        .commit_valid_i   (commit_valid_i),
        .pc_i             (pc_i),
        .in_delay_slot_i  (in_delay_slot_i),
        .cp0_epc_i        (cp0_epc_i),
        .redirect_ack_i   (redirect_ack_i),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .cp0_we_o         (cp0_we_o),
        .epc_o            (epc_o),
        .exccode_o        (exccode_o),
        .bd_o             (bd_o),
        .exl_set_o        (exl_set_o),
        .exl_clr_o        (exl_clr_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        excepttype_i    = '0;
        commit_valid_i  = 1'b0;
        pc_i            = '0;
        in_delay_slot_i = 1'b0;
        cp0_epc_i       = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".stall"},  32'(stall_o), 0);
        chk({tag, ".flush"},  32'(flush_o), 0);
        chk({tag, ".we"},     32'(cp0_we_o), 0);
        chk({tag, ".epc"},    epc_o, 0);
        chk({tag, ".cc"},     32'(exccode_o), 0);
        chk({tag, ".bd"},     32'(bd_o), 0);
        chk({tag, ".exls"},   32'(exl_set_o), 0);
        chk({tag, ".exlc"},   32'(exl_clr_o), 0);
        chk({tag, ".rvalid"}, 32'(redirect_valid_o), 0);
        chk({tag, ".rpc"},    redirect_pc_o, 0);
    endtask

    // Full sequence; caller is at #1 after a posedge with DUT in IDLE.
    task automatic run_seq(input string nm, input logic [31:0] code, input logic [31:0] pc,
                           input logic ds, input logic [31:0] cp0epc,
                           input logic [31:0] exp_epc, input logic [4:0] exp_cc,
                           input logic exp_bd, input logic is_eret,
                           input logic [31:0] exp_rpc, input int ack_wait,
                           input logic ack_early, input logic inject_in_flush);
        excepttype_i    = code;
        commit_valid_i  = 1'b1;
        pc_i            = pc;
        in_delay_slot_i = ds;
        cp0_epc_i       = cp0epc;
        redirect_ack_i  = ack_early;
        step();
        clear_inputs();
        chk({nm, ".save.stall"}, 32'(stall_o), 1);
        chk({nm, ".save.we"},    32'(cp0_we_o), 1);
        chk({nm, ".save.epc"},   epc_o, exp_epc);
        chk({nm, ".save.cc"},    32'(exccode_o), 32'(exp_cc));
        chk({nm, ".save.bd"},    32'(bd_o), 32'(exp_bd));
        chk({nm, ".save.exls"},  32'(exl_set_o), 32'(!is_eret));
        chk({nm, ".save.exlc"},  32'(exl_clr_o), 32'(is_eret));
        chk({nm, ".save.flush"}, 32'(flush_o), 0);
        for (int i = 0; i < 2; i++) begin
            if (inject_in_flush && i == 0) begin
                excepttype_i   = 32'h0000_000d;
                commit_valid_i = 1'b1;
                cp0_epc_i      = 32'h1234_5678;
            end
            step();
            clear_inputs();
            chk({nm, ".flush.flush"},  32'(flush_o), 1);
            chk({nm, ".flush.stall"},  32'(stall_o), 1);
            chk({nm, ".flush.we"},     32'(cp0_we_o), 0);
            chk({nm, ".flush.rvalid"}, 32'(redirect_valid_o), 0);
        end
        if (!ack_early) redirect_ack_i = 1'b0;
        step();
        chk({nm, ".redir.valid"}, 32'(redirect_valid_o), 1);
        chk({nm, ".redir.pc"},    redirect_pc_o, exp_rpc);
        chk({nm, ".redir.flush"}, 32'(flush_o), 0);
        chk({nm, ".redir.stall"}, 32'(stall_o), 1);
        for (int i = 0; i < ack_wait; i++) begin
            step();
            chk({nm, ".wait.valid"}, 32'(redirect_valid_o), 1);
            chk({nm, ".wait.pc"},    redirect_pc_o, exp_rpc);
            chk({nm, ".wait.stall"}, 32'(stall_o), 1);
            chk({nm, ".wait.we"},    32'(cp0_we_o), 0);
        end
        redirect_ack_i = 1'b1;
        step();
        redirect_ack_i = 1'b0;
        chk({nm, ".idle.stall"},  32'(stall_o), 0);
        chk({nm, ".idle.rvalid"}, 32'(redirect_valid_o), 0);
        chk({nm, ".idle.rpc"},    redirect_pc_o, 0);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_ack_i = 1'b0;
        clear_inputs();
        #2;
        check_all_zero("reset");
        step();
        step();
        rst = 1'b0;
        step();
        check_all_zero("post_reset");

        run_seq("syscall", 32'h9, 32'h0040_0010, 1'b0, 32'h0, 32'h0040_0010, 5'd8,
                1'b0, 1'b0, HPC, 0, 1'b0, 1'b0);
        run_seq("ov_ds", 32'hc, 32'h0040_0024, 1'b1, 32'h0, 32'h0040_0020, 5'd12,
                1'b1, 1'b0, HPC, 0, 1'b0, 1'b0);
        run_seq("eret", 32'hd, 32'h0040_0300, 1'b0, 32'h0040_0100, 32'h0, 5'd0,
                1'b0, 1'b1, 32'h0040_0100, 0, 1'b1, 1'b0);
        run_seq("int3_wait", 32'h3, 32'h0040_0200, 1'b0, 32'h0, 32'h0040_0200, 5'd0,
                1'b0, 1'b0, HPC, 5, 1'b0, 1'b0);
        run_seq("break_wrap", 32'ha, 32'h0, 1'b1, 32'h0, 32'hFFFF_FFFC, 5'd9,
                1'b1, 1'b0, HPC, 0, 1'b0, 1'b0);
        run_seq("ri_flushinj", 32'hb, 32'h0040_0044, 1'b0, 32'h0, 32'h0040_0044, 5'd10,
                1'b0, 1'b0, HPC, 1, 1'b0, 1'b1);

        // Codes that must not start a sequence
        excepttype_i = 32'h1f; commit_valid_i = 1'b1;
        step();
        chk("ign_1f.stall", 32'(stall_o), 0);
        chk("ign_1f.we",    32'(cp0_we_o), 0);
        excepttype_i = 32'he;
        step();
        chk("ign_0e.stall", 32'(stall_o), 0);
        excepttype_i = 32'h9; commit_valid_i = 1'b0;
        step();
        chk("ign_nocommit.stall", 32'(stall_o), 0);
        chk("ign_nocommit.we",    32'(cp0_we_o), 0);
        clear_inputs();
        step();

        // Asynchronous reset mid-FLUSH
        excepttype_i = 32'h9; commit_valid_i = 1'b1; pc_i = 32'h0040_0080;
        step();
        clear_inputs();
        chk("rstseq.save.we", 32'(cp0_we_o), 1);
        step();
        chk("rstseq.flush", 32'(flush_o), 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        step();
        rst = 1'b0;
        redirect_ack_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("after_rst.stall",  32'(stall_o), 0);
            chk("after_rst.rvalid", 32'(redirect_valid_o), 0);
            chk("after_rst.we",     32'(cp0_we_o), 0);
        end
        redirect_ack_i = 1'b0;

        // Back-to-back: new exception accepted right after return to IDLE
        run_seq("after_rst_int", 32'h1, 32'h0040_0500, 1'b0, 32'h0, 32'h0040_0500, 5'd0,
                1'b0, 1'b0, HPC, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
